serial_chunk_add_sub: RTL
=========================

Name: serial_chunk_add_sub

Overview:
Parametrised multi-cycle adder/subtractor, the successor to the fixed 4-bit ripple adder. Operands are captured on a valid/ready handshake and processed CHUNK bits per clock through one shared ripple-carry slice. The carry is registered between chunks. The block returns a WIDTH+1-bit result plus carry, overflow, zero and negative flags. It sits in the datapath wherever a wide add/sub is needed at low area and multi-cycle latency is acceptable.

Parameters:
WIDTH, 16, operand width in bits; must be >= 2.
CHUNK, 4, bits processed per cycle; must divide WIDTH exactly; CHUNK = WIDTH gives single-step operation.

Ports:
clk  input  1  rising-edge clock; the single clock of the block.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand/command valid.
in_ready  output  1  block can accept; high only in IDLE.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B, 1 = A-B (computed as A + ~B + 1).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
s  output  WIDTH+1  result; s[WIDTH] = final carry.
c  output  1  final carry out of the MSB; for sub, 1 = no borrow.
o  output  1  signed overflow = carry into MSB XOR carry out of MSB.
z  output  1  1 when s[WIDTH-1:0] == 0.
n  output  1  s[WIDTH-1].

Behaviour:
- NSTEP = WIDTH/CHUNK. State machine has three states:
  - IDLE: in_ready=1.
  - BUSY: processing chunks.
  - DONE: out_valid=1.
- Reset (async assert, any state): state=IDLE, step counter=0, carry reg=0, operand/result regs=0; s=0, c=o=z=n=0, out_valid=0; in_ready=1 once reset is released.
- Reset mid-BUSY or mid-DONE aborts the operation. No output is produced for the aborted operation.
- IDLE -> BUSY on in_valid && in_ready at edge T0:
  - latch a, b^{WIDTH{sub}}, and sub;
  - carry reg := sub;
  - step := 0.
- BUSY: each edge processes chunk k = step, bits [k*CHUNK +: CHUNK]:
  - write the sum bits into the result register;
  - carry reg := chunk carry-out;
  - step++.
  - On the final chunk (k = NSTEP-1), also capture the carry into the MSB (for o) and go to DONE.
- out_valid rises exactly NSTEP cycles after the accept edge T0; the first cycle with out_valid=1 follows edge T_NSTEP.
- c, o, z, n and s are registered and valid only when out_valid=1. While out_valid=1 they are held stable.
- DONE -> IDLE on out_ready. While out_ready=0, all outputs hold indefinitely and in_ready stays 0.
- No same-cycle turnaround: in_ready returns to 1 in the cycle after the output handshake. Minimum issue interval is NSTEP+2 cycles.
- in_valid while not in IDLE is ignored; a, b and sub are don't-care outside the accept cycle.
- Arithmetic is modulo 2^WIDTH with the carry extended into s[WIDTH], for both add and sub. For sub, c=0 means A<B unsigned.
- With CHUNK = WIDTH, BUSY lasts one cycle, so latency is 1.

Decomposition:
- Shared package (add_sub_pkg):
  - state encoding typedef (IDLE/BUSY/DONE);
  - localparam NSTEP;
  - localparam step-counter width = $clog2(NSTEP) with a minimum of 1.
- One sub-module, chunk_ripple_adder, parameterised by CHUNK:
  - inputs: CHUNK-bit x and y, c_in;
  - outputs: CHUNK-bit sum, c_out, and c_msb_in (carry into its top bit);
  - built as a chain of one_bit_full_adder instances via generate.
- The top level holds the FSM, the step counter and the shift/indexing of operand and result registers.

Test Plan:
- Default params, add 0x7FFF+0x0001 -> s=0x08000, c=0, o=1, z=0, n=1; out_valid exactly 4 cycles after the accept edge.
- Add 0xFFFF+0x0001 -> s=0x10000, c=1, o=0, z=1, n=0.
- Sub 0x0005-0x0007 -> s=0x0FFFE, c=0, o=0, n=1. Sub 0x8000-0x0001 -> s=0x17FFF, c=1, o=1, n=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> s/flags constant, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 next cycle, and a second operation completes correctly.
- Reset: assert rst_n=0 at step 2 of BUSY -> outputs zero immediately (async) and in_ready=1 after release. The next operation 0x1234+0x4321 gives s=0x05555 with no stale carry.
- Config WIDTH=8, CHUNK=8: 0x80+0x80 -> s=0x100, c=1, o=1, z=1; latency 1 cycle. Finish with a random sweep against a reference model for WIDTH=12, CHUNK=3.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial chunked adder/subtractor: FSM encoding
// and step-count helpers used by the top level.
package add_sub_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_BUSY = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   // A one-step configuration still needs a one-bit counter to stay legal.
   function automatic int step_width(input int nstep);
      return (nstep <= 1) ? 1 : $clog2(nstep);
   endfunction

   function automatic int num_steps(input int width, input int chunk);
      return width / chunk;
   endfunction

   localparam int NSTEP  = DEF_WIDTH / DEF_CHUNK;
   localparam int STEP_W = step_width(NSTEP);

endpackage

// File: rtl/chunk_ripple_adder.sv
// CHUNK-bit ripple-carry slice built from single-bit full adders; also
// reports the carry into its top bit so the caller can derive overflow.
module one_bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module chunk_ripple_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [CHUNK:0] carry;

   assign carry[0] = c_in;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      one_bit_full_adder u_fa (
         .a  (x[i]),
         .b  (y[i]),
         .ci (carry[i]),
         .s  (sum[i]),
         .co (carry[i+1])
      );
   end

   assign c_out    = carry[CHUNK];
   assign c_msb_in = carry[CHUNK-1];

endmodule

// File: rtl/serial_chunk_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor: one shared CHUNK-bit ripple slice
// walks the operands low chunk first, with the carry registered between steps.
module serial_chunk_add_sub
   import add_sub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   s,
   output logic             c,
   output logic             o,
   output logic             z,
   output logic             n,
   output state_t           dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // in_ready is high only in IDLE, out_valid only in DONE; the result is
   // held unchanged until the consumer takes it.

   localparam int N_STEPS = num_steps(WIDTH, CHUNK);
   localparam int SW      = step_width(N_STEPS);
   localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);

   state_t           state_q, state_d;
   logic [SW-1:0]    step_q, step_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             c_q, c_d;
   logic             o_q, o_d;
   logic             z_q, z_d;
   logic             n_q, n_d;

   logic [CHUNK-1:0] x_chunk;
   logic [CHUNK-1:0] y_chunk;
   logic [CHUNK-1:0] sum_chunk;
   logic             chunk_cout;
   logic             chunk_cmsb;

   always_comb begin
      x_chunk = a_q[step_q*CHUNK +: CHUNK];
      y_chunk = b_q[step_q*CHUNK +: CHUNK];
   end

   chunk_ripple_adder #(
      .CHUNK (CHUNK)
   ) u_slice (
      .x        (x_chunk),
      .y        (y_chunk),
      .c_in     (carry_q),
      .sum      (sum_chunk),
      .c_out    (chunk_cout),
      .c_msb_in (chunk_cmsb)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      o_d     = o_q;
      z_d     = z_q;
      n_d     = n_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               // Subtraction is A + ~B + 1: invert B now, inject the +1 as carry-in.
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub;
               step_d  = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            res_d[step_q*CHUNK +: CHUNK] = sum_chunk;
            carry_d = chunk_cout;
            if (step_q == LAST_STEP) begin
               step_d  = '0;
               c_d     = chunk_cout;
               o_d     = chunk_cmsb ^ chunk_cout;
               z_d     = (res_d == '0);
               n_d     = res_d[WIDTH-1];
               state_d = ST_DONE;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         o_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         o_q     <= o_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign s         = {c_q, res_q};
   assign c         = c_q;
   assign o         = o_q;
   assign z         = z_q;
   assign n         = n_q;
   assign dbg_state = state_q;

endmodule
